uart_rx_serial: RTL and testbench

- Serial UART receiver: deserialises the asynchronous uart_rxd line into bytes and feeds the ZX-Uno UART register block through the uart_rx_data / uart_rx_req write port of its 64-byte RX FIFO.
- Also converts that block's uart_rx_fifo_full watermark into an active-low RTS output for hardware flow control toward the remote sender.
- Sits between the board RXD/RTS pins and the UART register emulation, on clk_bus.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/sync_2ff.sv | 35 +++
 rtl/uart_rx_serial.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_serial.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types, frame constants and baud helpers for the UART.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Clock cycles per bit, integer-truncated
    function automatic int baud_divisor(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Clock cycles per half bit, used to land in the middle of the start bit
    function automatic int baud_half(input int clk_hz, input int baud);
        return baud_divisor(clk_hz, baud) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Parameterised-width two-flop synchroniser with a caller-
//                supplied reset value (idle level of the synchronised line).
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two back-to-back flops; the first may go metastable, the second settles it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= rst_val;
            r_sync <= rst_val;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_serial.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_serial
//  Description : 8N1 UART receiver feeding the RX FIFO write port, plus an
//                RTS output registered from the FIFO watermark.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_serial
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 28000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk_bus,
    input  logic       reset_n,
    input  logic       uart_rxd,
    input  logic       uart_rx_fifo_full,
    output logic [7:0] uart_rx_data,
    output logic       uart_rx_req,
    output logic       uart_rx_frame_err,
    output logic       uart_rx_busy,
    output logic       uart_rts_n
);

    localparam int DIVISOR = baud_divisor(CLK_HZ, BAUD);
    localparam int HALF    = baud_half(CLK_HZ, BAUD);
    localparam int CNT_W   = $clog2(DIVISOR);

    localparam logic [CNT_W-1:0] c_half_last = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] c_div_last  = CNT_W'(DIVISOR - 1);
    localparam logic [2:0]       c_last_bit  = 3'(DATA_BITS - 1);

    if (DIVISOR < 4) begin : g_bad_divisor
        $error("uart_rx_serial: CLK_HZ/BAUD must be at least 4");
    end

    if (STOP_BITS != 1) begin : g_bad_stop_bits
        $error("uart_rx_serial: only one stop bit is supported");
    end

    logic                 w_rxs;
    rx_state_t            r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_break;
    logic                 r_req_pend;
    logic [7:0]           r_data;
    logic                 r_req;
    logic                 r_frame_err;
    logic                 r_busy;
    logic                 r_rts_n;

    sync_2ff #(
        .WIDTH (1)
    ) u_rxd_sync (
        .clk     (clk_bus),
        .rst_n   (reset_n),
        .rst_val (1'b1),
        .d       (uart_rxd),
        .q       (w_rxs)
    );

    // Frame FSM: half-bit start qualification, mid-bit sampling, stop check
    always_ff @(posedge clk_bus or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_break     <= 1'b0;
            r_req_pend  <= 1'b0;
            r_data      <= 8'h00;
            r_req       <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // Strobes are single-cycle; the write strobe trails the data load by one cycle
            r_frame_err <= 1'b0;
            r_req       <= r_req_pend;
            r_req_pend  <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (r_break) begin
                        // A held-low line after a framing error must go high before re-arming
                        if (w_rxs) begin
                            r_break <= 1'b0;
                        end
                    end else if (!w_rxs) begin
                        r_state <= START;
                        r_busy  <= 1'b1;
                    end
                end

                START: begin
                    if (r_cnt == c_half_last) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (r_cnt == c_div_last) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= w_rxs;
                        if (r_bit_idx == c_last_bit) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (r_cnt == c_div_last) begin
                        // Leave at mid-stop so a following start edge is never missed
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        if (w_rxs) begin
                            r_data     <= r_shift;
                            r_req_pend <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_break     <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // RTS simply mirrors the FIFO watermark one cycle later; reception is never gated
    always_ff @(posedge clk_bus or negedge reset_n) begin
        if (!reset_n) begin
            r_rts_n <= 1'b1;
        end else begin
            r_rts_n <= uart_rx_fifo_full;
        end
    end

    assign uart_rx_data      = r_data;
    assign uart_rx_req       = r_req;
    assign uart_rx_frame_err = r_frame_err;
    assign uart_rx_busy      = r_busy;
    assign uart_rts_n        = r_rts_n;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_serial
//  Description : Directed self-checking bench for uart_rx_serial at 16 clocks
//                per bit (CLK_HZ=16, BAUD=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_serial;

    localparam int BIT_CYC = 16;

    logic       clk_bus;
    logic       reset_n;
    logic       uart_rxd;
    logic       uart_rx_fifo_full;
    logic [7:0] uart_rx_data;
    logic       uart_rx_req;
    logic       uart_rx_frame_err;
    logic       uart_rx_busy;
    logic       uart_rts_n;

    int checks   = 0;
    int failures = 0;

    int req_cnt     = 0;
    int ferr_cnt    = 0;
    int busy_cycles = 0;
    int long_req    = 0;
    logic req_prev  = 1'b0;
    logic [7:0] rx_q[$];

    uart_rx_serial #(
        .CLK_HZ (16),
        .BAUD   (1)
    ) dut (
        .clk_bus           (clk_bus),
        .reset_n           (reset_n),
        .uart_rxd          (uart_rxd),
        .uart_rx_fifo_full (uart_rx_fifo_full),
        .uart_rx_data      (uart_rx_data),
        .uart_rx_req       (uart_rx_req),
        .uart_rx_frame_err (uart_rx_frame_err),
        .uart_rx_busy      (uart_rx_busy),
        .uart_rts_n        (uart_rts_n)
    );

    initial clk_bus = 1'b0;
    always #5 clk_bus = ~clk_bus;

    // Observe the write port and status strobes away from the active edge
    always @(negedge clk_bus) begin
        if (uart_rx_req) begin
            req_cnt++;
            rx_q.push_back(uart_rx_data);
            if (req_prev) long_req++;
        end
        if (uart_rx_frame_err) ferr_cnt++;
        if (uart_rx_busy) busy_cycles++;
        req_prev = uart_rx_req;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive the line to v for n clock cycles, ending 1 time unit after a rising edge
    task automatic hold(input logic v, input int n);
        uart_rxd = v;
        repeat (n) begin
            @(posedge clk_bus);
            #1;
        end
    endtask

    task automatic send_bits(input logic [7:0] d, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) hold(d[i], BIT_CYC);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        hold(1'b0, BIT_CYC);
        send_bits(d, 0, 7);
        hold(stop, BIT_CYC);
    endtask

    function automatic logic [31:0] q_at(input int idx);
        if (rx_q.size() > idx) return {24'h0, rx_q[idx]};
        return 'x;
    endfunction

    int r0, f0, b0, q0;

    initial begin
        reset_n           = 1'b0;
        uart_rxd          = 1'b1;
        uart_rx_fifo_full = 1'b0;
        repeat (3) @(posedge clk_bus);
        #1;

        // Reset state
        check("rst_data",  uart_rx_data, 8'h00);
        check("rst_req",   uart_rx_req, 1'b0);
        check("rst_ferr",  uart_rx_frame_err, 1'b0);
        check("rst_busy",  uart_rx_busy, 1'b0);
        check("rst_rts_n", uart_rts_n, 1'b1);

        // Release between edges: RTS stays high until the next clock
        reset_n = 1'b1;
        #1;
        check("rts_before_clk", uart_rts_n, 1'b1);
        @(posedge clk_bus);
        #1;
        check("rts_after_clk", uart_rts_n, 1'b0);

        hold(1'b1, 100);
        check("idle_busy", uart_rx_busy, 1'b0);
        check("idle_req",  req_cnt, 0);
        check("idle_ferr", ferr_cnt, 0);

        // Frame 0x55
        r0 = req_cnt; f0 = ferr_cnt; b0 = busy_cycles; q0 = rx_q.size();
        send_frame(8'h55, 1'b1);
        hold(1'b1, 20);
        check("f55_req_cnt",  req_cnt - r0, 1);
        check("f55_data",     q_at(q0), 8'h55);
        check("f55_port",     uart_rx_data, 8'h55);
        check("f55_req_long", long_req, 0);
        check("f55_ferr",     ferr_cnt - f0, 0);
        check("f55_busy_seen", (busy_cycles - b0) > 100, 1'b1);
        check("f55_busy_end", uart_rx_busy, 1'b0);

        // Short low glitch must be rejected in START
        r0 = req_cnt; f0 = ferr_cnt;
        hold(1'b0, 5);
        hold(1'b1, 40);
        check("glitch_req",  req_cnt - r0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_busy", uart_rx_busy, 1'b0);

        // Frame 0xA3 with low stop bit, line held low as a break
        r0 = req_cnt; f0 = ferr_cnt;
        send_frame(8'hA3, 1'b0);
        hold(1'b0, 200);
        hold(1'b1, 40);
        check("brk_ferr_cnt", ferr_cnt - f0, 1);
        check("brk_req",      req_cnt - r0, 0);
        check("brk_data",     uart_rx_data, 8'h55);
        check("brk_busy",     uart_rx_busy, 1'b0);

        // Receiver re-armed after the break ends
        r0 = req_cnt; q0 = rx_q.size();
        send_frame(8'h0F, 1'b1);
        hold(1'b1, 20);
        check("f0f_req_cnt", req_cnt - r0, 1);
        check("f0f_data",    q_at(q0), 8'h0F);

        // Back-to-back 0x00 then 0xFF, second start right at stop-bit end
        r0 = req_cnt; q0 = rx_q.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        hold(1'b1, 20);
        check("b2b_req_cnt", req_cnt - r0, 2);
        check("b2b_first",   q_at(q0), 8'h00);
        check("b2b_second",  q_at(q0 + 1), 8'hFF);
        check("b2b_req_long", long_req, 0);

        // Frame 0x7E with the FIFO watermark rising mid-frame
        r0 = req_cnt; q0 = rx_q.size();
        hold(1'b0, BIT_CYC);
        send_bits(8'h7E, 0, 3);
        uart_rx_fifo_full = 1'b1;
        #1;
        check("rts_not_yet", uart_rts_n, 1'b0);
        hold(1'b1, 1);               // bit 4 of 0x7E is 1
        check("rts_high", uart_rts_n, 1'b1);
        hold(1'b1, BIT_CYC - 1);
        send_bits(8'h7E, 5, 7);
        hold(1'b1, BIT_CYC);
        hold(1'b1, 20);
        check("f7e_req_cnt", req_cnt - r0, 1);
        check("f7e_data",    q_at(q0), 8'h7E);

        uart_rx_fifo_full = 1'b0;
        hold(1'b1, 3);
        check("rts_low_again", uart_rts_n, 1'b0);

        // Frame 0x11 aborted by reset mid-frame
        r0 = req_cnt; f0 = ferr_cnt;
        hold(1'b0, BIT_CYC);
        send_bits(8'h11, 0, 3);
        check("f11_busy_mid", uart_rx_busy, 1'b1);
        reset_n  = 1'b0;
        uart_rxd = 1'b1;
        #1;
        check("arst_data",  uart_rx_data, 8'h00);
        check("arst_req",   uart_rx_req, 1'b0);
        check("arst_ferr",  uart_rx_frame_err, 1'b0);
        check("arst_busy",  uart_rx_busy, 1'b0);
        check("arst_rts_n", uart_rts_n, 1'b1);
        hold(1'b1, 3);
        reset_n = 1'b1;
        hold(1'b1, 200);
        check("f11_req_cnt", req_cnt - r0, 0);
        check("f11_ferr",    ferr_cnt - f0, 0);
        check("f11_data",    uart_rx_data, 8'h00);
        check("f11_busy",    uart_rx_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
